// File: rtl/banked_lane_memory.sv
// Byte-lane-banked single-port data memory with a two-cycle registered read path.
// Define MEM_INIT_CLEAR_EN to zero every word after reset before requests are taken.
module banked_lane_memory #(
    parameter int LANES      = 4,
    parameter int LANE_WIDTH = 8,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_wren,
    input  logic [LANES-1:0]              req_byteen,
    input  logic [ADDR_WIDTH-1:0]         req_address,
    input  logic [LANES*LANE_WIDTH-1:0]   req_data,
    output logic                          rsp_valid,
    output logic [LANES*LANE_WIDTH-1:0]   rsp_q,
    output logic                          rsp_error,
    output logic                          busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DW    = LANES * LANE_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    logic             accept;
    logic             in_range;
    logic             rd_en;
    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [DW-1:0]    wr_data;
    logic [LANES-1:0] wr_lane;
    logic [DW-1:0]    rd_word;

    logic             s1_valid_q;
    logic             s1_err_q;
    logic             rsp_valid_q;
    logic             rsp_error_q;
    logic [DW-1:0]    rsp_data_q;

    assign accept   = req_valid & req_ready;
    assign in_range = {1'b0, req_address} < DEPTH_EXT;
    assign req_idx  = req_address[IDX_W-1:0];
    // Out-of-range reads never touch storage, so the index is always legal.
    assign rd_en    = accept & ~req_wren & in_range;

`ifdef MEM_INIT_CLEAR_EN
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= ST_INIT;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        req_ready = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_INIT: begin
                busy = 1'b1;
                if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d   = ST_RUN;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: req_ready = 1'b1;
        endcase
    end
`else
    assign req_ready = 1'b1;
    assign busy      = 1'b0;
`endif

    always_comb begin
        wr_idx  = req_idx;
        wr_data = req_data;
        wr_lane = (accept && req_wren && in_range) ? req_byteen : '0;
`ifdef MEM_INIT_CLEAR_EN
        if (state_q == ST_INIT) begin
            wr_idx  = clr_cnt_q;
            wr_data = '0;
            wr_lane = '1;
        end
`endif
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [LANE_WIDTH-1:0] mem [DEPTH];
            logic [LANE_WIDTH-1:0] rd_q;

            always_ff @(posedge clock) begin
                if (wr_lane[gi]) begin
                    mem[wr_idx] <= wr_data[gi*LANE_WIDTH +: LANE_WIDTH];
                end
                if (rd_en) begin
                    rd_q <= mem[req_idx];
                end
            end

            assign rd_word[gi*LANE_WIDTH +: LANE_WIDTH] = rd_q;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_err_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            s1_valid_q  <= accept & ~req_wren;
            s1_err_q    <= accept & ~req_wren & ~in_range;
            rsp_valid_q <= s1_valid_q;
            rsp_error_q <= s1_valid_q & s1_err_q;
            rsp_data_q  <= (s1_valid_q && !s1_err_q) ? rd_word : '0;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_error = rsp_error_q;
    assign rsp_q     = rsp_data_q;

endmodule

// File: tb/tb_banked_lane_memory.sv
// Directed bench for banked_lane_memory: default geometry plus a 2x16-bit, 256-deep instance.
module tb_banked_lane_memory;

`ifdef MEM_INIT_CLEAR_EN
    localparam int INIT_A = 1024;
    localparam int INIT_B = 256;
`else
    localparam int INIT_A = 0;
    localparam int INIT_B = 0;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_wren;
    logic [3:0]  req_byteen;
    logic [15:0] req_address;
    logic [31:0] req_data;
    logic        rsp_valid, rsp_error, busy;
    logic [31:0] rsp_q;

    logic        b_req_valid, b_req_ready, b_req_wren;
    logic [1:0]  b_req_byteen;
    logic [15:0] b_req_address;
    logic [31:0] b_req_data;
    logic        b_rsp_valid, b_rsp_error, b_busy;
    logic [31:0] b_rsp_q;

    always #5 clock = ~clock;

    banked_lane_memory dut (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_wren(req_wren), .req_byteen(req_byteen), .req_address(req_address),
        .req_data(req_data), .rsp_valid(rsp_valid), .rsp_q(rsp_q),
        .rsp_error(rsp_error), .busy(busy)
    );

    banked_lane_memory #(.LANES(2), .LANE_WIDTH(16), .DEPTH(256), .ADDR_WIDTH(16)) dut_b (
        .clock(clock), .reset_n(reset_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_wren(b_req_wren), .req_byteen(b_req_byteen), .req_address(b_req_address),
        .req_data(b_req_data), .rsp_valid(b_rsp_valid), .rsp_q(b_rsp_q),
        .rsp_error(b_rsp_error), .busy(b_busy)
    );

    typedef struct {
        logic        wren;
        logic [3:0]  be;
        logic [15:0] addr;
        logic [31:0] data;
        logic [31:0] exp_q;
        logic        exp_err;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [31:0] q;
        logic        err;
    } rsp_t;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    rsp_t got_q[$];
    rsp_t exp_q[$];
    vec_t tbl[$];

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (rsp_valid) got_q.push_back('{cyc, rsp_q, rsp_error});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [3:0] be, input logic [15:0] a,
                                input logic [31:0] d, input logic [31:0] eq, input logic ee);
        vec_t v;
        v.wren = w; v.be = be; v.addr = a; v.data = d; v.exp_q = eq; v.exp_err = ee;
        return v;
    endfunction

    task automatic issue(input vec_t v);
        @(negedge clock);
        chk("ready_at_issue", {31'd0, req_ready}, 32'd1);
        req_valid   = 1'b1;
        req_wren    = v.wren;
        req_byteen  = v.be;
        req_address = v.addr;
        req_data    = v.data;
        if (!v.wren) exp_q.push_back('{cyc + 2, v.exp_q, v.exp_err});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            req_valid = 1'b0;
        end
    endtask

    task automatic check_rsps(input string tag);
        int n;
        idle(4);
        chk({tag, "_rsp_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_rsp%0d_cycle", tag, i), got_q[i].cyc, exp_q[i].cyc);
            chk($sformatf("%s_rsp%0d_q", tag, i), got_q[i].q, exp_q[i].q);
            chk($sformatf("%s_rsp%0d_err", tag, i), {31'd0, got_q[i].err}, {31'd0, exp_q[i].err});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // Counts cycles with req_ready low, starting at the current negedge; bounded.
    task automatic count_init(input string tag, output int n_low);
        n_low = 0;
        for (int i = 0; i < 2000; i++) begin
            if (req_ready) break;
            n_low++;
            @(negedge clock);
        end
        chk({tag, "_init_cycles"}, n_low, INIT_A);
        chk({tag, "_busy_after_init"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n_low;
        reset_n = 1'b0;
        req_valid = 1'b0; req_wren = 1'b0; req_byteen = '0; req_address = '0; req_data = '0;
        b_req_valid = 1'b0; b_req_wren = 1'b0; b_req_byteen = '0; b_req_address = '0; b_req_data = '0;

        repeat (3) @(negedge clock);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_q", rsp_q, 32'd0);
        chk("rst_rsp_error", {31'd0, rsp_error}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, (INIT_A == 0) ? 32'd1 : 32'd0);
        chk("rst_busy", {31'd0, busy}, (INIT_A == 0) ? 32'd0 : 32'd1);
        chk("rst_b_ready", {31'd0, b_req_ready}, (INIT_B == 0) ? 32'd1 : 32'd0);
        reset_n = 1'b1;
        count_init("power_on", n_low);

`ifdef MEM_INIT_CLEAR_EN
        issue(mk(1'b0, 4'h0, 16'h03FF, 32'h0, 32'h0000_0000, 1'b0));
        check_rsps("cleared_top");
`endif

        tbl.push_back(mk(1'b1, 4'b1111, 16'h0010, 32'hDEADBEEF, 32'h0, 1'b0));
        tbl.push_back(mk(1'b1, 4'b0101, 16'h0010, 32'h11223344, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 16'h0010, 32'h0, 32'hDE22BE44, 1'b0));
        tbl.push_back(mk(1'b1, 4'b1111, 16'h0020, 32'hCAFEF00D, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 16'h0020, 32'h0, 32'hCAFEF00D, 1'b0));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1'b1, 4'b1111, 16'(i), 32'hA500_0000 | 32'(i), 32'h0, 1'b0));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1'b0, 4'b0000, 16'(i), 32'h0, 32'hA500_0000 | 32'(i), 1'b0));
        tbl.push_back(mk(1'b1, 4'b1111, 16'h0400, 32'hFFFFFFFF, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 16'h0400, 32'h0, 32'h0000_0000, 1'b1));
        tbl.push_back(mk(1'b0, 4'b0000, 16'h0000, 32'h0, 32'hA500_0000, 1'b0));
        tbl.push_back(mk(1'b1, 4'b1111, 16'h0030, 32'h0BADF00D, 32'h0, 1'b0));
        tbl.push_back(mk(1'b1, 4'b0000, 16'h0030, 32'h12345678, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 16'h0030, 32'h0, 32'h0BADF00D, 1'b0));
        tbl.push_back(mk(1'b1, 4'b1111, 16'h03FF, 32'h77665544, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 16'h03FF, 32'h0, 32'h77665544, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 16'hFFFF, 32'h0, 32'h0000_0000, 1'b1));
        tbl.push_back(mk(1'b0, 4'b0000, 16'h0007, 32'h0, 32'hA500_0007, 1'b0));
        foreach (tbl[i]) issue(tbl[i]);
        check_rsps("table");

        // Narrow-lane instance: upper-lane-only write over a zeroed word.
        @(negedge clock);
        chk("b_ready", {31'd0, b_req_ready}, 32'd1);
        b_req_valid = 1'b1; b_req_wren = 1'b1; b_req_byteen = 2'b11;
        b_req_address = 16'h0005; b_req_data = 32'h0000_0000;
        @(negedge clock);
        b_req_byteen = 2'b10; b_req_data = 32'hABCD_1234;
        @(negedge clock);
        b_req_wren = 1'b0; b_req_byteen = 2'b00; b_req_data = 32'h0;
        @(negedge clock);
        b_req_valid = 1'b0;
        chk("b_rsp_valid_early", {31'd0, b_rsp_valid}, 32'd0);
        @(negedge clock);
        chk("b_rsp_valid", {31'd0, b_rsp_valid}, 32'd1);
        chk("b_rsp_q", b_rsp_q, 32'hABCD_0000);
        chk("b_rsp_error", {31'd0, b_rsp_error}, 32'd0);

        // Reads in flight when reset hits must never respond.
        got_q.delete();
        @(negedge clock);
        req_valid = 1'b1; req_wren = 1'b0; req_byteen = '0; req_address = 16'h0010;
        @(negedge clock);
        req_address = 16'h0020;
        reset_n = 1'b0;
        @(negedge clock);
        req_valid = 1'b0;
        reset_n = 1'b1;
        chk("flush_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        count_init("flush", n_low);
        idle(6);
        chk("flush_no_rsp", got_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/banked_lane_memory.md
# banked_lane_memory

Parametrised, byte-lane-banked single-port data memory for the matrix-multiplication datapath. It replaces fixed-geometry memory wrappers with a configurable lane count, lane width and depth. It adds a valid/ready request interface, per-lane write enables, out-of-range detection and a fixed two-cycle pipelined read path. An optional post-reset clear sweep is selected at compile time.

## Interface
- LANES, 4, number of independent byte-lane banks; data word is LANES*LANE_WIDTH bits
- LANE_WIDTH, 8, bits per lane
- DEPTH, 1024, words per lane; legal addresses 0..DEPTH-1
- ADDR_WIDTH, 16, request address width; must satisfy 2^ADDR_WIDTH >= DEPTH
- clock  input  1  single clock; all logic on rising edge
- reset_n  input  1  synchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block accepts a request this cycle
- req_wren  input  1  1 = write, 0 = read
- req_byteen  input  LANES  per-lane write enable; bit i gates lane i; ignored on reads
- req_address  input  ADDR_WIDTH  word address
- req_data  input  LANES*LANE_WIDTH  write data; lane i = bits [i*LANE_WIDTH +: LANE_WIDTH]
- rsp_valid  output  1  read response valid, one-cycle pulse per accepted read
- rsp_q  output  LANES*LANE_WIDTH  read data
- rsp_error  output  1  qualifies rsp_valid; read address was out of range
- busy  output  1  clear sweep in progress

## Operation
- Accept = req_valid & req_ready. At most one request per cycle. No response backpressure.
- States:
  - INIT: clear sweep, present only with the macro.
  - RUN: req_ready=1, busy=0.
- Write: each lane i with req_byteen[i]=1 stores its slice at req_address. Other lanes are unchanged. Byteen all-zero is a legal no-op.
- Read: all lanes read at req_address and are concatenated lane LANES-1 (MSB) down to lane 0.
- Out of range (req_address >= DEPTH):
  - Write is dropped with no aliasing.
  - Read returns rsp_q=0 with rsp_error=1.
  - No state change otherwise.
- In-range reads return rsp_error=0.
- Responses return strictly in request order.
- Reset (reset_n=0 sampled at an edge):
  - rsp_valid=0, rsp_q=0, rsp_error=0.
  - Read pipeline is flushed: reads in flight produce no response.
  - State goes to INIT (macro) or RUN (no macro).
  - Memory contents are not cleared by reset itself.

## Timing
- Read accepted in cycle 0 → storage read registered at end of cycle 0 → output registered at end of cycle 1 → rsp_valid/rsp_q/rsp_error high in cycle 2 only.
- Fully pipelined: N consecutive accepted reads yield N consecutive responses.
- Write accepted in cycle 0 commits at the end of cycle 0. A read of the same address accepted in cycle 1 or later returns the new data.
- Write followed by a read to the same address produces no hazard stall. req_ready is unaffected by traffic.
- Outputs during reset and in the first cycle after it:
  - req_ready=0 (macro) or 1 (no macro).
  - busy=1 (macro) or 0 (no macro).
  - rsp_valid=0.

## Configuration
- MEM_INIT_CLEAR_EN defined:
  - After reset releases, INIT writes all-zero to every lane at addresses 0..DEPTH-1, one word per cycle, using an internal counter.
  - req_ready=0 and busy=1 for exactly DEPTH cycles, then RUN.
  - Requests during INIT are not accepted.
  - Reset asserted mid-sweep restarts the sweep from address 0.
- MEM_INIT_CLEAR_EN undefined:
  - No INIT state and no sweep counter; busy is tied 0.
  - RUN is entered in the first cycle after reset; contents are whatever the storage holds (initialisation-file or undefined).

## Test plan
- Macro on, defaults: reset_n low 3 cycles then high → req_ready low exactly 1024 cycles with busy=1, then high. Read 0x03FF → rsp_q=0x00000000, rsp_error=0.
- Write 0xDEADBEEF to 0x0010 with byteen 4'b1111, then 0x11223344 with byteen 4'b0101, then read 0x0010 → rsp_q=0xDE22BE44 in cycle 2 after the read accept.
- Write 0xCAFEF00D to 0x0020 in cycle 0, read 0x0020 in cycle 1 → rsp_valid in cycle 3 with 0xCAFEF00D. Eight back-to-back reads of 0x0000..0x0007 → eight consecutive rsp_valid pulses in address order.
- Write 0xFFFFFFFF to 0x0400, then read 0x0400 and 0x0000:
  - 0x0400 → rsp_q=0x00000000, rsp_error=1.
  - 0x0000 → prior value unchanged, rsp_error=0.
- Reads accepted in cycles 0 and 1, reset_n low in cycle 1 → no rsp_valid pulse. Macro on: sweep restarts and req_ready stays low 1024 cycles after release.
- Macro off, LANES=2, LANE_WIDTH=16, DEPTH=256 → req_ready=1 in first cycle after reset. Write 0xABCD1234 with byteen 2'b10 over 0x00000000, then read → 0xABCD0000.
